// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default sizing for the result-CDB arbiter and its requesting FUs.
package cdb_arbiter_pkg;

  localparam int NUM_CDB_REQ      = 4;
  localparam int CDB_PRIO_IDX     = 3;
  localparam int CDB_STARVE_LIMIT = 4;

  localparam int ROB_ID_W   = 5;
  localparam int PHY_REG_W  = 6;
  localparam int ARCH_REG_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MDU = 2'd1,
    FU_LSU = 2'd2,
    FU_BR  = 2'd3
  } fu_idx_e;

  typedef struct packed {
    logic [ROB_ID_W-1:0]   rob_id;
    logic [PHY_REG_W-1:0]  rd_phy;
    logic [ARCH_REG_W-1:0] rd_arch;
    logic [XLEN-1:0]       rd_value;
    logic [XLEN-1:0]       rs1_value_dbg;
    logic [XLEN-1:0]       rs2_value_dbg;
  } fu_cdb_reg_t;

  localparam int FU_CDB_W = $bits(fu_cdb_reg_t);

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin picker: first set bit of i_mask scanning upward from i_ptr, wrapping modulo NUM_REQ.
module rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = NUM_CDB_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  int w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_valid && i_mask[IDX_W'(w_cand)]) begin
        o_valid                  = 1'b1;
        o_grant[IDX_W'(w_cand)] = 1'b1;
        o_idx                    = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates the single result CDB among the FUs: branch FU first (starvation-bounded),
// round robin for the rest, one registered result per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int  NUM_REQ      = NUM_CDB_REQ,
  parameter int  PRIO_IDX     = CDB_PRIO_IDX,
  parameter int  STARVE_LIMIT = CDB_STARVE_LIMIT,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*FU_CDB_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_cdb_valid,
  output logic [ROB_ID_W-1:0]       o_cdb_rob_id,
  output logic [PHY_REG_W-1:0]      o_cdb_rd_phy,
  output logic [ARCH_REG_W-1:0]     o_cdb_rd_arch,
  output logic [XLEN-1:0]           o_cdb_rd_value,
  output logic [XLEN-1:0]           o_cdb_rs1_value_dbg,
  output logic [XLEN-1:0]           o_cdb_rs2_value_dbg,
  output logic [IDX_W-1:0]          o_cdb_src
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]   LIMIT_C  = CNT_W'(STARVE_LIMIT);
  localparam logic [NUM_REQ-1:0] PRIO_BIT = NUM_REQ'(1) << PRIO_IDX;
  localparam logic [IDX_W-1:0]   PRIO_I   = IDX_W'(PRIO_IDX);
  localparam logic [IDX_W-1:0]   LAST_I   = IDX_W'(NUM_REQ - 1);

  fu_cdb_reg_t        w_req_arr [NUM_REQ];
  logic [NUM_REQ-1:0] w_rr_mask;
  logic               w_other_valid;
  logic [NUM_REQ-1:0] w_rr_grant;
  logic [IDX_W-1:0]   w_rr_idx;
  logic               w_rr_valid;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_valid;
  logic               w_gnt_prio;

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic               r_cdb_valid;
  fu_cdb_reg_t        r_cdb_data;
  logic [IDX_W-1:0]   r_cdb_src;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_arr[i] = i_req_data[i*FU_CDB_W +: FU_CDB_W];
    end
  end

  assign w_rr_mask     = i_req_valid & ~PRIO_BIT;
  assign w_other_valid = |w_rr_mask;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
    .i_mask  (w_rr_mask),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

  // No grant while in reset so an FU never sees a handshake that the output stage will discard.
  always_comb begin
    w_grant     = '0;
    w_gnt_idx   = '0;
    w_gnt_valid = 1'b0;
    w_gnt_prio  = 1'b0;
    if (!i_rst && !i_flush) begin
      if (i_req_valid[PRIO_IDX] && ((r_starve_cnt < LIMIT_C) || !w_other_valid)) begin
        w_grant     = PRIO_BIT;
        w_gnt_idx   = PRIO_I;
        w_gnt_valid = 1'b1;
        w_gnt_prio  = 1'b1;
      end else if (w_rr_valid) begin
        w_grant     = w_rr_grant;
        w_gnt_idx   = w_rr_idx;
        w_gnt_valid = 1'b1;
      end
    end
  end

  assign o_req_ready = w_grant;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cdb_valid  <= 1'b0;
      r_cdb_data   <= '0;
      r_cdb_src    <= '0;
      r_rr_ptr     <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_cdb_valid <= w_gnt_valid;
      if (w_gnt_valid) begin
        r_cdb_data <= w_req_arr[w_gnt_idx];
        r_cdb_src  <= w_gnt_idx;
      end
      if (i_flush) begin
        r_rr_ptr     <= '0;
        r_starve_cnt <= '0;
      end else begin
        if (w_gnt_valid && !w_gnt_prio) begin
          r_rr_ptr <= (w_gnt_idx == LAST_I) ? '0 : w_gnt_idx + IDX_W'(1);
        end
        // The counter only measures branch grants that actually made someone else wait.
        if (!w_other_valid || (w_gnt_valid && !w_gnt_prio)) begin
          r_starve_cnt <= '0;
        end else if (w_gnt_prio && (r_starve_cnt != LIMIT_C)) begin
          r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_cdb_valid         = r_cdb_valid;
  assign o_cdb_rob_id        = r_cdb_data.rob_id;
  assign o_cdb_rd_phy        = r_cdb_data.rd_phy;
  assign o_cdb_rd_arch       = r_cdb_data.rd_arch;
  assign o_cdb_rd_value      = r_cdb_data.rd_value;
  assign o_cdb_rs1_value_dbg = r_cdb_data.rs1_value_dbg;
  assign o_cdb_rs2_value_dbg = r_cdb_data.rs2_value_dbg;
  assign o_cdb_src           = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single requester, round robin, branch priority with
// starvation bound, flush and grant-shape invariants.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                        clk;
  logic                        rst;
  logic                        flush;
  logic [3:0]                  reqValid;
  logic [4*FU_CDB_W-1:0]       reqData;
  logic [3:0]                  reqReady;
  logic                        cdbValid;
  logic [ROB_ID_W-1:0]         cdbRobId;
  logic [PHY_REG_W-1:0]        cdbRdPhy;
  logic [ARCH_REG_W-1:0]       cdbRdArch;
  logic [XLEN-1:0]             cdbRdValue;
  logic [XLEN-1:0]             cdbRs1Dbg;
  logic [XLEN-1:0]             cdbRs2Dbg;
  logic [1:0]                  cdbSrc;

  logic [ROB_ID_W-1:0]         robOf [4];
  int                          vecCount;
  int                          errCount;

  cdb_arbiter dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_flush             (flush),
    .i_req_valid         (reqValid),
    .i_req_data          (reqData),
    .o_req_ready         (reqReady),
    .o_cdb_valid         (cdbValid),
    .o_cdb_rob_id        (cdbRobId),
    .o_cdb_rd_phy        (cdbRdPhy),
    .o_cdb_rd_arch       (cdbRdArch),
    .o_cdb_rd_value      (cdbRdValue),
    .o_cdb_rs1_value_dbg (cdbRs1Dbg),
    .o_cdb_rs2_value_dbg (cdbRs2Dbg),
    .o_cdb_src           (cdbSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fu_cdb_reg_t mkData(int idx, logic [ROB_ID_W-1:0] rob);
    fu_cdb_reg_t d;
    d.rob_id        = rob;
    d.rd_phy        = PHY_REG_W'(16 + idx);
    d.rd_arch       = ARCH_REG_W'(idx + 1);
    d.rd_value      = 32'hCAFE_0000 + 32'(idx);
    d.rs1_value_dbg = 32'(idx * 3 + 7);
    d.rs2_value_dbg = 32'h0000_1000 + 32'(idx);
    return d;
  endfunction

  always_comb begin
    reqData = '0;
    for (int i = 0; i < 4; i++) begin
      reqData[i*FU_CDB_W +: FU_CDB_W] = mkData(i, robOf[i]);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of requests after the falling edge, check the combinational grant, then
  // step past the rising edge so the registered CDB reflects this cycle's grant.
  task automatic applyStimulus(input logic [3:0] vld, input logic flsh, input logic [3:0] expRdy,
                               input string tag);
    @(negedge clk);
    reqValid = vld;
    flush    = flsh;
    #1;
    checkOutput({tag, "_ready"}, 64'(reqReady), 64'(expRdy));
    @(posedge clk);
    #1;
  endtask

  task automatic checkCdb(input string tag, input logic expValid, input int expSrc);
    fu_cdb_reg_t e;
    checkOutput({tag, "_cdb_valid"}, 64'(cdbValid), 64'(expValid));
    if (expValid) begin
      e = mkData(expSrc, robOf[expSrc]);
      checkOutput({tag, "_cdb_src"}, 64'(cdbSrc), 64'(expSrc));
      checkOutput({tag, "_cdb_rob"}, 64'(cdbRobId), 64'(e.rob_id));
      checkOutput({tag, "_cdb_rd"}, 64'({cdbRdPhy, cdbRdArch, cdbRdValue}),
                  64'({e.rd_phy, e.rd_arch, e.rd_value}));
      checkOutput({tag, "_cdb_dbg"}, {cdbRs1Dbg, cdbRs2Dbg}, {e.rs1_value_dbg, e.rs2_value_dbg});
    end
  endtask

  always @(negedge clk) begin
    #3;
    checkOutput("onehot0_ready", 64'($onehot0(reqReady)), 64'd1);
    checkOutput("ready_implies_valid", 64'(reqReady & ~reqValid), 64'd0);
  end

  int   rrSrc [6]  = '{0, 1, 2, 0, 1, 2};
  int   stSrc [10] = '{3, 3, 3, 3, 0, 3, 3, 3, 3, 0};
  int   grantCycle;
  logic fu1Granted;

  initial begin
    vecCount = 0;
    errCount = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    reqValid = 4'b0000;
    robOf    = '{5'd10, 5'd11, 5'd12, 5'd13};

    #2;
    checkOutput("reset_cdb_valid", 64'(cdbValid), 64'd0);
    checkOutput("reset_cdb_src", 64'(cdbSrc), 64'd0);
    checkOutput("reset_cdb_payload", 64'({cdbRobId, cdbRdValue}), 64'd0);
    reqValid = 4'b1111;
    #1;
    checkOutput("reset_no_grant", 64'(reqReady), 64'd0);
    @(negedge clk);
    reqValid = 4'b0000;
    rst      = 1'b0;

    // Single requester with rob_id 5 on FU1; afterwards rr_ptr points at 2.
    robOf[1] = 5'd5;
    applyStimulus(4'b0010, 1'b0, 4'b0010, "single");
    checkOutput("single_rob_id", 64'(cdbRobId), 64'd5);
    checkCdb("single", 1'b1, 1);
    applyStimulus(4'b0000, 1'b0, 4'b0000, "idle");
    checkCdb("idle", 1'b0, 0);
    applyStimulus(4'b0110, 1'b0, 4'b0100, "ptr_at_2");
    checkCdb("ptr_at_2", 1'b1, 2);

    // Asynchronous reset between clock edges while everyone requests.
    reqValid = 4'b1111;
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_cdb_valid", 64'(cdbValid), 64'd0);
    checkOutput("async_rst_cdb_rob", 64'(cdbRobId), 64'd0);
    checkOutput("async_rst_ready", 64'(reqReady), 64'd0);
    @(negedge clk);
    reqValid = 4'b0000;
    rst      = 1'b0;
    applyStimulus(4'b0110, 1'b0, 4'b0010, "ptr_after_rst");
    checkCdb("ptr_after_rst", 1'b1, 1);

    applyStimulus(4'b0000, 1'b1, 4'b0000, "flush_idle");
    checkCdb("flush_idle", 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b0111, 1'b0, 4'(1 << rrSrc[i]), $sformatf("rr%0d", i));
      checkCdb($sformatf("rr%0d", i), 1'b1, rrSrc[i]);
    end

    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1001, 1'b0, 4'(1 << stSrc[i]), $sformatf("starve%0d", i));
      checkCdb($sformatf("starve%0d", i), 1'b1, stSrc[i]);
    end

    // Flush drops the next registered result but not the one already on the bus.
    applyStimulus(4'b0100, 1'b0, 4'b0100, "pre_flush_fu2");
    checkCdb("flush_t1", 1'b1, 2);
    applyStimulus(4'b1111, 1'b1, 4'b0000, "flush_all_valid");
    checkCdb("flush_t2", 1'b0, 0);

    // Flush must clear both rr_ptr and a partially built starve count.
    applyStimulus(4'b0010, 1'b0, 4'b0010, "fl_ptr_setup");
    applyStimulus(4'b1010, 1'b0, 4'b1000, "fl_cnt_a");
    applyStimulus(4'b1010, 1'b0, 4'b1000, "fl_cnt_b");
    applyStimulus(4'b1111, 1'b1, 4'b0000, "fl_clear");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1110, 1'b0, 4'b1000, $sformatf("fl_prio%0d", i));
    end
    applyStimulus(4'b1110, 1'b0, 4'b0010, "fl_rr_from_0");
    checkCdb("fl_rr_from_0", 1'b1, 1);

    // FU1 waiting behind a permanently valid branch FU gets through within the bound.
    fu1Granted = 1'b0;
    grantCycle = 0;
    for (int c = 1; c <= CDB_STARVE_LIMIT + 1; c++) begin
      if (!fu1Granted) begin
        @(negedge clk);
        reqValid = 4'b1010;
        flush    = 1'b0;
        #1;
        if (reqReady[1]) begin
          fu1Granted = 1'b1;
          grantCycle = c;
        end
        @(posedge clk);
        #1;
      end
    end
    checkOutput("fu1_granted_in_bound", 64'(fu1Granted), 64'd1);
    checkOutput("fu1_grant_cycle", 64'(grantCycle), 64'(CDB_STARVE_LIMIT + 1));

    // A lone requester is served every cycle.
    for (int i = 0; i < 3; i++) begin
      robOf[0] = 5'(20 + i);
      applyStimulus(4'b0001, 1'b0, 4'b0001, $sformatf("lone_alu%0d", i));
      checkCdb($sformatf("lone_alu%0d", i), 1'b1, 0);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1000, 1'b0, 4'b1000, $sformatf("lone_br%0d", i));
      checkCdb($sformatf("lone_br%0d", i), 1'b1, 3);
    end
    applyStimulus(4'b0000, 1'b0, 4'b0000, "final_idle");
    checkCdb("final_idle", 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
